// File: rtl/byte_stream_ram_writer_pkg.sv
// Shared definitions for the byte-stream RAM write feeder: default geometry,
// word/enable/address types and the write-pointer FSM encoding.
package byte_ram_pkg;

  localparam int NUM_COL    = 4;
  localparam int COL_WIDTH  = 8;
  localparam int ADDR_WIDTH = 10;
  localparam int DATA_WIDTH = NUM_COL * COL_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [NUM_COL-1:0]    be_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // RUN: bytes accepted and written; FULL: pointer exhausted (WRAP=0 only).
  typedef enum logic {
    RUN  = 1'b0,
    FULL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/byte_stream_ram_writer_if.sv
// Byte-stream input plus RAM write-port output of the feeder.
//
// Handshake: a byte transfers on a rising clk edge where s_valid && s_ready.
// s_ready depends only on the registered full flag, never on s_valid, so the
// source may hold s_valid/s_data/s_last stable until it sees s_ready high.
// clear and flush are single-cycle commands sampled on every edge.
interface byte_stream_ram_writer_if #(
  parameter int NUM_COL    = byte_ram_pkg::NUM_COL,
  parameter int COL_WIDTH  = byte_ram_pkg::COL_WIDTH,
  parameter int ADDR_WIDTH = byte_ram_pkg::ADDR_WIDTH
);
  import byte_ram_pkg::*;

  logic                         clear;
  logic                         s_valid;
  logic                         s_ready;
  logic [COL_WIDTH-1:0]         s_data;
  logic                         s_last;
  logic                         flush;
  logic [NUM_COL-1:0]           we;
  logic [ADDR_WIDTH-1:0]        write_addr;
  logic [NUM_COL*COL_WIDTH-1:0] din;
  logic                         wr_strobe;
  logic                         done;
  logic                         wrapped;
  logic                         full;
  wr_state_e                    dbg_state;

  // Upstream byte source / observer of the RAM write port.
  modport master (
    output clear, s_valid, s_data, s_last, flush,
    input  s_ready, we, write_addr, din, wr_strobe, done, wrapped, full, dbg_state
  );

  // The writer itself.
  modport slave (
    input  clear, s_valid, s_data, s_last, flush,
    output s_ready, we, write_addr, din, wr_strobe, done, wrapped, full, dbg_state
  );

endinterface

// File: rtl/byte_stream_ram_writer_byte_lane_packer.sv
// Packs accepted bytes little-endian into a word, tracking which lanes are
// filled. The emit/be/data outputs already include the byte being accepted
// this cycle, so the top can register the write with one cycle of latency.
module byte_lane_packer #(
  parameter int NUM_COL   = 4,
  parameter int COL_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clear,
  input  logic                         i_accept,
  input  logic [COL_WIDTH-1:0]         i_data,
  input  logic                         i_last,
  input  logic                         i_flush,
  output logic                         o_emit,
  output logic                         o_last,
  output logic [NUM_COL-1:0]           o_be,
  output logic [NUM_COL*COL_WIDTH-1:0] o_data
);
  import byte_ram_pkg::*;

  localparam int LW = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam logic [LW-1:0] LANE_MAX = LW'(NUM_COL - 1);

  logic [LW-1:0]                r_lane;
  logic [NUM_COL-1:0]           r_be;
  logic [NUM_COL*COL_WIDTH-1:0] r_data;
  logic [NUM_COL-1:0]           w_be;
  logic [NUM_COL*COL_WIDTH-1:0] w_data;
  logic                         w_emit;

  // Merge the incoming byte into the accumulators and decide whether to emit.
  always_comb begin
    w_be   = r_be;
    w_data = r_data;
    if (i_accept) begin
      w_be[r_lane]                            = 1'b1;
      w_data[r_lane*COL_WIDTH +: COL_WIDTH]   = i_data;
    end
    w_emit = (i_accept && ((r_lane == LANE_MAX) || i_last)) ||
             (i_flush && ((r_lane != '0) || i_accept));
  end

  // Lane counter and accumulators; emptied on emit so unfilled lanes read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lane <= '0;
      r_be   <= '0;
      r_data <= '0;
    end else if (i_clear || w_emit) begin
      r_lane <= '0;
      r_be   <= '0;
      r_data <= '0;
    end else if (i_accept) begin
      r_lane <= r_lane + 1'b1;
      r_be   <= w_be;
      r_data <= w_data;
    end
  end

  assign o_emit = w_emit;
  assign o_last = i_accept && i_last;
  assign o_be   = w_be;
  assign o_data = w_data;

endmodule

// File: rtl/byte_stream_ram_writer.sv
// Byte-stream to byte-write RAM feeder: one registered RAM write per packed
// word, auto-incrementing address, optional wrap or stop-when-full.
module byte_stream_ram_writer #(
  parameter int NUM_COL    = byte_ram_pkg::NUM_COL,
  parameter int COL_WIDTH  = byte_ram_pkg::COL_WIDTH,
  parameter int ADDR_WIDTH = byte_ram_pkg::ADDR_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDR = '1,
  parameter bit WRAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  byte_stream_ram_writer_if.slave bus
);
  import byte_ram_pkg::*;

  wr_state_e                    r_state;
  wr_state_e                    w_state_next;
  logic [ADDR_WIDTH-1:0]        r_ptr;
  logic [ADDR_WIDTH-1:0]        w_ptr_next;
  logic                         w_wrap_now;
  logic                         w_full;
  logic                         w_accept;
  logic                         w_flush;
  logic                         w_emit;
  logic                         w_last;
  logic [NUM_COL-1:0]           w_be;
  logic [NUM_COL*COL_WIDTH-1:0] w_data;

  logic [NUM_COL-1:0]           r_we;
  logic [ADDR_WIDTH-1:0]        r_addr;
  logic [NUM_COL*COL_WIDTH-1:0] r_din;
  logic                         r_strobe;
  logic                         r_done;
  logic                         r_wrapped;

  // In FULL the accumulators are empty, so gating accept and flush is enough
  // to freeze the datapath until clear.
  assign w_full   = (r_state == FULL);
  assign w_accept = bus.s_valid && !w_full;
  assign w_flush  = bus.flush && !w_full;

  byte_lane_packer #(
    .NUM_COL  (NUM_COL),
    .COL_WIDTH(COL_WIDTH)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (bus.clear),
    .i_accept(w_accept),
    .i_data  (bus.s_data),
    .i_last  (bus.s_last),
    .i_flush (w_flush),
    .o_emit  (w_emit),
    .o_last  (w_last),
    .o_be    (w_be),
    .o_data  (w_data)
  );

  // Next state / next pointer: advance on each emitted word, wrap or stop at the end.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_wrap_now   = 1'b0;
    if (bus.clear) begin
      w_state_next = RUN;
      w_ptr_next   = BASE_ADDR;
    end else if (r_state == RUN && w_emit) begin
      if (r_ptr == LAST_ADDR) begin
        if (WRAP) begin
          w_ptr_next = BASE_ADDR;
          w_wrap_now = 1'b1;
        end else begin
          w_state_next = FULL;
        end
      end else begin
        w_ptr_next = r_ptr + 1'b1;
      end
    end
  end

  // State and write-pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= RUN;
      r_ptr   <= BASE_ADDR;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Registered RAM write port; address and data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we      <= '0;
      r_addr    <= BASE_ADDR;
      r_din     <= '0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (bus.clear) begin
      r_we      <= '0;
      r_addr    <= BASE_ADDR;
      r_din     <= '0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end else if (w_emit) begin
      r_we      <= w_be;
      r_addr    <= r_ptr;
      r_din     <= w_data;
      r_strobe  <= 1'b1;
      r_done    <= w_last;
      r_wrapped <= w_wrap_now;
    end else begin
      r_we      <= '0;
      r_strobe  <= 1'b0;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end
  end

  assign bus.s_ready    = !w_full;
  assign bus.full       = w_full;
  assign bus.we         = r_we;
  assign bus.write_addr = r_addr;
  assign bus.din        = r_din;
  assign bus.wr_strobe  = r_strobe;
  assign bus.done       = r_done;
  assign bus.wrapped    = r_wrapped;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_byte_stream_ram_writer.sv
// Bench for byte_stream_ram_writer: three instances (default config, 4-word
// stop-when-full, 4-word wrapping) driven one at a time against a queue-based
// reference model of the packing/addressing rules.
module tb_byte_stream_ram_writer;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  byte_stream_ram_writer_if #(.ADDR_WIDTH(10)) bus0 ();
  byte_stream_ram_writer_if #(.ADDR_WIDTH(2))  bus1 ();
  byte_stream_ram_writer_if #(.ADDR_WIDTH(2))  bus2 ();

  byte_stream_ram_writer #(.ADDR_WIDTH(10), .WRAP(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  byte_stream_ram_writer #(.ADDR_WIDTH(2),  .WRAP(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  byte_stream_ram_writer #(.ADDR_WIDTH(2),  .WRAP(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int sel   = 0;

  // ---------------- reference model ----------------
  int          m_last;
  bit          m_wrap;
  bit          m_full;
  int          m_ptr;
  logic [7:0]  pend[$];
  logic [45:0] exp_q[$];   // {addr[9:0], we[3:0], din[31:0]}
  logic [3:0]  e_we;
  logic [9:0]  e_addr;
  logic [31:0] e_din;
  logic        e_strobe, e_done, e_wrapped;

  task automatic model_reset();
    m_ptr = 0; m_full = 0; pend.delete(); exp_q.delete();
    e_we = '0; e_addr = '0; e_din = '0; e_strobe = 0; e_done = 0; e_wrapped = 0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit l, input bit f, input bit c);
    bit acc, emit;
    logic [31:0] w;
    logic [3:0]  be;
    e_we = '0; e_strobe = 0; e_done = 0; e_wrapped = 0;
    if (c) begin
      pend.delete(); m_ptr = 0; m_full = 0; e_addr = '0; e_din = '0;
      return;
    end
    acc = v && !m_full;
    if (acc) pend.push_back(d);
    emit = (acc && (pend.size() == 4 || l)) || (f && !m_full && pend.size() > 0);
    if (emit) begin
      w = '0; be = '0;
      foreach (pend[i]) begin
        w[i*8 +: 8] = pend[i];
        be[i]       = 1'b1;
      end
      e_we = be; e_din = w; e_addr = 10'(m_ptr); e_strobe = 1; e_done = acc && l;
      exp_q.push_back({10'(m_ptr), be, w});
      if (m_ptr == m_last) begin
        if (m_wrap) begin m_ptr = 0; e_wrapped = 1; end
        else m_full = 1;
      end else begin
        m_ptr++;
      end
      pend.delete();
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, sel, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0]  o_we;
    logic [9:0]  o_addr;
    logic [31:0] o_din;
    logic        o_strobe, o_done, o_wrapped, o_full, o_ready;
    logic [45:0] exp;
    case (sel)
      0: begin o_we = bus0.we; o_addr = bus0.write_addr; o_din = bus0.din; o_strobe = bus0.wr_strobe;
               o_done = bus0.done; o_wrapped = bus0.wrapped; o_full = bus0.full; o_ready = bus0.s_ready; end
      1: begin o_we = bus1.we; o_addr = {8'b0, bus1.write_addr}; o_din = bus1.din; o_strobe = bus1.wr_strobe;
               o_done = bus1.done; o_wrapped = bus1.wrapped; o_full = bus1.full; o_ready = bus1.s_ready; end
      default: begin o_we = bus2.we; o_addr = {8'b0, bus2.write_addr}; o_din = bus2.din; o_strobe = bus2.wr_strobe;
               o_done = bus2.done; o_wrapped = bus2.wrapped; o_full = bus2.full; o_ready = bus2.s_ready; end
    endcase
    chk("we",         64'(o_we),      64'(e_we));
    chk("wr_strobe",  64'(o_strobe),  64'(e_strobe));
    chk("done",       64'(o_done),    64'(e_done));
    chk("wrapped",    64'(o_wrapped), 64'(e_wrapped));
    chk("full",       64'(o_full),    64'(m_full));
    chk("s_ready",    64'(o_ready),   64'(!m_full));
    chk("write_addr", 64'(o_addr),    64'(e_addr));
    chk("din",        64'(o_din),     64'(e_din));
    if (e_strobe) begin
      exp = exp_q.pop_front();
      chk("write_record", 64'({o_addr, o_we, o_din}), 64'(exp));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit v, input logic [7:0] d, input bit l, input bit f, input bit c);
    bus0.s_valid = 0; bus0.s_data = '0; bus0.s_last = 0; bus0.flush = 0; bus0.clear = 0;
    bus1.s_valid = 0; bus1.s_data = '0; bus1.s_last = 0; bus1.flush = 0; bus1.clear = 0;
    bus2.s_valid = 0; bus2.s_data = '0; bus2.s_last = 0; bus2.flush = 0; bus2.clear = 0;
    case (sel)
      0: begin bus0.s_valid = v; bus0.s_data = d; bus0.s_last = l; bus0.flush = f; bus0.clear = c; end
      1: begin bus1.s_valid = v; bus1.s_data = d; bus1.s_last = l; bus1.flush = f; bus1.clear = c; end
      default: begin bus2.s_valid = v; bus2.s_data = d; bus2.s_last = l; bus2.flush = f; bus2.clear = c; end
    endcase
  endtask

  // One clock: drive, advance the model, sample 1 time unit after the edge.
  task automatic step(input bit v, input logic [7:0] d, input bit l, input bit f, input bit c);
    drive(v, d, l, f, c);
    model_step(v, d, l, f, c);
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset asserted between edges, checked before any clock edge.
  task automatic do_reset();
    drive(0, '0, 0, 0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  task automatic begin_phase(input int s);
    sel    = s;
    m_last = (s == 0) ? 1023 : 3;
    m_wrap = (s != 1);
    do_reset();
  endtask

  task automatic send_bytes(input int n, input logic [7:0] first, input logic [7:0] inc);
    logic [7:0] b;
    b = first;
    for (int i = 0; i < n; i++) begin
      step(1, b, 0, 0, 0);
      b = b + inc;
    end
  endtask

  task automatic random_run(input int cycles, input int clr_odds);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, clr_odds) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive(0, '0, 0, 0, 0);
    @(posedge clk);
    #1;

    // Two full words 0x11..0x88 on consecutive addresses.
    begin_phase(0);
    send_bytes(8, 8'h11, 8'h11);
    step(0, '0, 0, 0, 0);

    // Short packet with s_last, then the following word.
    begin_phase(0);
    step(1, 8'hAA, 0, 0, 0);
    step(1, 8'hBB, 1, 0, 0);
    send_bytes(4, 8'hC0, 8'h01);
    step(0, '0, 0, 0, 0);

    // Partial word by flush; second flush with nothing pending is a no-op.
    begin_phase(0);
    send_bytes(3, 8'h01, 8'h01);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 0);

    // Flush coincident with an accept, and s_last on the final lane.
    step(1, 8'h5A, 0, 1, 0);
    send_bytes(3, 8'h21, 8'h01);
    step(1, 8'h24, 1, 0, 0);
    step(0, '0, 0, 0, 0);

    // clear mid-word with a coincident byte and flush: nothing written.
    send_bytes(2, 8'h31, 8'h01);
    step(1, 8'h33, 0, 1, 1);
    send_bytes(4, 8'h41, 8'h01);
    step(0, '0, 0, 0, 0);

    // Reset after two bytes drops the partial word.
    begin_phase(0);
    send_bytes(2, 8'hE1, 8'h01);
    do_reset();
    send_bytes(4, 8'h10, 8'h10);
    step(0, '0, 0, 0, 0);

    random_run(600, 63);

    // Stop-when-full: 16 bytes fill addrs 0..3, 17th is refused.
    begin_phase(1);
    send_bytes(16, 8'h01, 8'h01);
    step(1, 8'hFF, 0, 0, 0);
    step(1, 8'hFE, 1, 1, 0);
    step(0, '0, 0, 0, 1);
    send_bytes(4, 8'h71, 8'h01);
    step(0, '0, 0, 0, 0);
    random_run(300, 40);

    // Wrapping: 20 bytes, wrapped pulses on the addr-3 write.
    begin_phase(2);
    send_bytes(20, 8'h80, 8'h01);
    step(0, '0, 0, 0, 0);
    random_run(300, 63);

    drive(0, '0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
